// File: rtl/regfile_pkg.sv
// Shared register-file definitions: address/data widths and the write-request
// bundle that travels from the writeback muxes to the write-port arbiter.
package regfile_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for registers awaiting a long-latency result, with the
// three-port lookup that produces the decode stall.
module rf_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 set_en,
    input  logic [ADDR_W-1:0]    set_addr,
    input  logic                 clr_en,
    input  logic [ADDR_W-1:0]    clr_addr,
    input  logic [ADDR_W-1:0]    rd_a1,
    input  logic [ADDR_W-1:0]    rd_a2,
    input  logic [ADDR_W-1:0]    rd_a3,
    output logic                 stall,
    output logic [2**ADDR_W-1:0] busy
);
    import regfile_pkg::*;

    localparam int NREG = 2**ADDR_W;

    logic [NREG-1:0] busy_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_reg[gi] = 1'b0;
            end else begin : g_flop
                logic set_hit;
                logic clr_hit;
                assign set_hit = set_en && (set_addr == ADDR_W'(gi));
                assign clr_hit = clr_en && (clr_addr == ADDR_W'(gi));
                // A set in the same cycle as a clear wins: the new op owns the register.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        busy_reg[gi] <= 1'b0;
                    end else if (set_hit) begin
                        busy_reg[gi] <= 1'b1;
                    end else if (clr_hit) begin
                        busy_reg[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    logic hit_a1;
    logic hit_a2;
    logic hit_a3;

    assign hit_a1 = busy_reg[rd_a1] && (rd_a1 != REG_ZERO);
    assign hit_a2 = busy_reg[rd_a2] && (rd_a2 != REG_ZERO);
    assign hit_a3 = busy_reg[rd_a3] && (rd_a3 != REG_ZERO);

    assign stall = hit_a1 | hit_a2 | hit_a3;
    assign busy  = busy_reg;

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Arbitrates the register file's single write port between single-cycle
// writeback (primary) and a long-latency unit (secondary) with anti-starvation.
module regfile_wport_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 p_valid,
    input  logic [ADDR_W-1:0]    p_addr,
    input  logic [DATA_W-1:0]    p_data,
    output logic                 p_ready,
    input  logic                 s_valid,
    input  logic [ADDR_W-1:0]    s_addr,
    input  logic [DATA_W-1:0]    s_data,
    output logic                 s_ready,
    input  logic                 iss_valid,
    input  logic [ADDR_W-1:0]    iss_addr,
    input  logic [ADDR_W-1:0]    dec_a1,
    input  logic [ADDR_W-1:0]    dec_a2,
    input  logic [ADDR_W-1:0]    dec_dst,
    output logic                 stall,
    output logic                 RegWrite,
    output logic [ADDR_W-1:0]    A3,
    output logic [DATA_W-1:0]    WD3,
    output logic [2**ADDR_W-1:0] busy
);
    import regfile_pkg::*;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] wait_cnt_reg;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             s_win;
    wr_req_t          grant;

    // Secondary also takes the port whenever primary is idle.
    always_comb begin
        s_win   = s_valid && (wait_cnt_reg == LIMIT);
        p_ready = 1'b0;
        s_ready = 1'b0;
        grant   = '0;
        if (!reset) begin
            if (s_valid && (s_win || !p_valid)) begin
                s_ready    = 1'b1;
                grant.valid = 1'b1;
                grant.addr  = s_addr;
                grant.data  = s_data;
            end else if (p_valid) begin
                p_ready    = 1'b1;
                grant.valid = 1'b1;
                grant.addr  = p_addr;
                grant.data  = p_data;
            end
        end
    end

    assign RegWrite = grant.valid && (grant.addr != REG_ZERO);
    assign A3       = grant.addr;
    assign WD3      = grant.data;

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (!s_valid || s_ready) begin
            wait_cnt_next = '0;
        end else if (wait_cnt_reg != LIMIT) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (iss_valid && (iss_addr != REG_ZERO)),
        .set_addr (iss_addr),
        .clr_en   (s_ready),
        .clr_addr (s_addr),
        .rd_a1    (dec_a1),
        .rd_a2    (dec_a2),
        .rd_a3    (dec_dst),
        .stall    (stall),
        .busy     (busy)
    );

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed-vector bench: each vector pushes its hand-computed expectation into a
// queue; a monitor on the falling edge pops and compares against the DUT.
module tb_regfile_wport_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 p_valid, s_valid, iss_valid;
    logic [ADDR_W-1:0]    p_addr, s_addr, iss_addr, dec_a1, dec_a2, dec_dst;
    logic [DATA_W-1:0]    p_data, s_data;
    logic                 p_ready, s_ready, stall, RegWrite;
    logic [ADDR_W-1:0]    A3;
    logic [DATA_W-1:0]    WD3;
    logic [2**ADDR_W-1:0] busy;

    typedef struct {
        string       name;
        logic        pr;
        logic        sr;
        logic        rw;
        logic [4:0]  a3;
        logic [31:0] wd3;
        logic        stall;
        logic [31:0] busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    regfile_wport_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(4), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset),
        .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data), .p_ready(p_ready),
        .s_valid(s_valid), .s_addr(s_addr), .s_data(s_data), .s_ready(s_ready),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .dec_a1(dec_a1), .dec_a2(dec_a2), .dec_dst(dec_dst), .stall(stall),
        .RegWrite(RegWrite), .A3(A3), .WD3(WD3), .busy(busy)
    );

    task automatic chk(input string name, input string field,
                       input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=0x%0h required=0x%0h", name, field, act, req);
        end
    endtask

    // One transaction per cycle, checked on the falling edge of the same cycle.
    always @(negedge clk) begin
        if (iss_valid && !reset && busy[iss_addr])
            $error("protocol violation: issue to busy register %0d", iss_addr);
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "p_ready",  64'(p_ready),  64'(e.pr));
            chk(e.name, "s_ready",  64'(s_ready),  64'(e.sr));
            chk(e.name, "RegWrite", 64'(RegWrite), 64'(e.rw));
            chk(e.name, "A3",       64'(A3),       64'(e.a3));
            chk(e.name, "WD3",      64'(WD3),      64'(e.wd3));
            chk(e.name, "stall",    64'(stall),    64'(e.stall));
            chk(e.name, "busy",     64'(busy),     64'(e.busy));
            $display("txn %-10s p_ready=%0d s_ready=%0d RegWrite=%0d A3=%0d WD3=0x%08h stall=%0d busy=0x%08h",
                     e.name, p_ready, s_ready, RegWrite, A3, WD3, stall, busy);
        end
    end

    task automatic vec(input string name, input logic rst,
                       input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                       input logic sv, input logic [4:0] sa, input logic [31:0] sd,
                       input logic iv, input logic [4:0] ia,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] dst,
                       input logic e_pr, input logic e_sr, input logic e_rw,
                       input logic [4:0] e_a3, input logic [31:0] e_wd3,
                       input logic e_stall, input logic [31:0] e_busy);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        p_valid = pv; p_addr = pa; p_data = pd;
        s_valid = sv; s_addr = sa; s_data = sd;
        iss_valid = iv; iss_addr = ia;
        dec_a1 = a1; dec_a2 = a2; dec_dst = dst;
        e.name = name; e.pr = e_pr; e.sr = e_sr; e.rw = e_rw; e.a3 = e_a3;
        e.wd3 = e_wd3; e.stall = e_stall; e.busy = e_busy;
        exp_q.push_back(e);
    endtask

    localparam logic [31:0] B3  = 32'h0000_0008;
    localparam logic [31:0] B5  = 32'h0000_0020;
    localparam logic [31:0] B12 = 32'h0000_1000;

    initial begin
        reset = 1'b1;
        p_valid = 0; p_addr = 0; p_data = 0;
        s_valid = 0; s_addr = 0; s_data = 0;
        iss_valid = 0; iss_addr = 0;
        dec_a1 = 0; dec_a2 = 0; dec_dst = 0;

        //    name          rst pv pa pd            sv sa sd         iv ia  a1 a2 dst  pr sr rw a3 wd3           st busy
        vec("reset",      1, 1, 8, 32'hDEADBEEF, 0, 0, 0,         0, 0,  0, 0, 0,   0, 0, 0, 0, 32'h0,        0, 0);
        vec("p_only",     0, 1, 8, 32'hDEADBEEF, 0, 0, 0,         0, 0,  0, 0, 0,   1, 0, 1, 8, 32'hDEADBEEF, 0, 0);
        for (int i = 0; i < 4; i++)
            vec("p_wins",   0, 1, 9, 32'h11,       1, 10, 32'h22,   0, 0,  0, 0, 0,   1, 0, 1, 9, 32'h11,       0, 0);
        vec("starve",     0, 1, 9, 32'h11,       1, 10, 32'h22,   0, 0,  0, 0, 0,   0, 1, 1, 10, 32'h22,      0, 0);
        vec("cnt_clr",    0, 1, 9, 32'h11,       1, 10, 32'h22,   0, 0,  0, 0, 0,   1, 0, 1, 9, 32'h11,       0, 0);
        vec("issue5",     0, 0, 0, 0,            0, 0, 0,         1, 5,  0, 0, 0,   0, 0, 0, 0, 32'h0,        0, 0);
        vec("stall5",     0, 0, 0, 0,            0, 0, 0,         0, 0,  5, 0, 0,   0, 0, 0, 0, 32'h0,        1, B5);
        vec("s_grant5",   0, 0, 0, 0,            1, 5, 32'h55,    0, 0,  5, 0, 0,   0, 1, 1, 5, 32'h55,       1, B5);
        vec("unstall5",   0, 0, 0, 0,            0, 0, 0,         0, 0,  5, 0, 0,   0, 0, 0, 0, 32'h0,        0, 0);
        vec("setclr12",   0, 0, 0, 0,            1, 12, 32'hC,    1, 12, 0, 0, 0,   0, 1, 1, 12, 32'hC,       0, 0);
        vec("busy12",     0, 0, 0, 0,            0, 0, 0,         0, 0,  0, 0, 12,  0, 0, 0, 0, 32'h0,        1, B12);
        vec("wr_r0",      0, 1, 0, 32'h1,        0, 0, 0,         1, 0,  0, 0, 0,   1, 0, 0, 0, 32'h1,        0, B12);
        vec("iss_r0",     0, 0, 0, 0,            0, 0, 0,         0, 0,  0, 0, 0,   0, 0, 0, 0, 32'h0,        0, B12);
        vec("issue3",     0, 0, 0, 0,            0, 0, 0,         1, 3,  0, 0, 0,   0, 0, 0, 0, 32'h0,        0, B12);
        for (int i = 0; i < 3; i++)
            vec("wait3",    0, 1, 9, 32'h11,       1, 10, 32'h22,   0, 0,  0, 3, 0,   1, 0, 1, 9, 32'h11,       1, B12 | B3);
        vec("rst_mid",    1, 1, 9, 32'h11,       1, 10, 32'h22,   0, 0,  0, 3, 0,   0, 0, 0, 0, 32'h0,        0, 0);
        for (int i = 0; i < 4; i++)
            vec("post_rst", 0, 1, 9, 32'h11,       1, 10, 32'h22,   0, 0,  0, 3, 0,   1, 0, 1, 9, 32'h11,       0, 0);
        vec("starve2",    0, 1, 9, 32'h11,       1, 10, 32'h22,   0, 0,  0, 3, 0,   0, 1, 1, 10, 32'h22,      0, 0);
        vec("idle",       0, 0, 0, 0,            0, 0, 0,         0, 0,  0, 0, 0,   0, 0, 0, 0, 32'h0,        0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
